decoder: RTL and testbench
==========================

DECODER -- requirements
Module: decoder

Interface
REQ-001 Parameter: ROUNDS, default 32, number of cipher cycles; each cycle is one z-step plus one y-step; legal range 1..255.
REQ-002 Parameter: DELTA, default 32'h9E3779B9, round constant.
REQ-003 Port: clock  input  1  single clock; all state updates on rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-005 Port: enable  input  1  advance enable; when low, all state holds.
REQ-006 Port: data_in  input  128  ciphertext; lane0 y=[31:0], z=[63:32]; lane1 y=[95:64], z=[127:96].
REQ-007 Port: key_in  input  128  key words k[n]=key_in[32n+31:32n], n=0..3.
REQ-008 Port: data_out  output  128  plaintext, same lane/word packing as data_in.
REQ-009 Port: done  output  1  plaintext valid in data_out.

Function
REQ-010 FSM states SHALL be IDLE, ZSTEP, YSTEP, OUTPUT; every transition is gated by enable=1.
REQ-011 IDLE, enable=1: load y0,z0,y1,z1 from data_in; sum <= (ROUNDS*DELTA) mod 2^32 (32'hC6EF3720 at defaults); round counter <= 0; done <= 0; go to ZSTEP.
REQ-012 ZSTEP: for each lane, z <= z - ((((y<<4)^(y>>5))+y) ^ (sum + k[sum[12:11]])); sum <= sum - DELTA; go to YSTEP.
REQ-013 YSTEP: for each lane, y <= y - ((((z<<4)^(z>>5))+z) ^ (sum + k[sum[1:0]])), using the sum already decremented in ZSTEP and the z updated in ZSTEP; increment round counter.
REQ-014 YSTEP exit: to ZSTEP if the incremented counter < ROUNDS, else to OUTPUT.
REQ-015 All arithmetic SHALL be unsigned 32-bit modulo 2^32; shifts logical; both lanes share sum and key word.
REQ-016 OUTPUT: data_out <= {z1,y1,z0,y0}; done <= 1; go to IDLE.
REQ-017 Latency with enable held high: done rises on the (2*ROUNDS+2)th rising edge after the load edge's predecessor, i.e. 66 edges from IDLE at defaults, counting the load edge.
REQ-018 done SHALL stay high until the next load edge; with enable held high it is high for exactly one cycle.
REQ-019 data_out SHALL hold its last value until the next OUTPUT state, including while a new block is processed.
REQ-020 data_in SHALL be sampled only on the load edge; later changes have no effect on the block in flight.
REQ-021 enable low in any state SHALL freeze state, registers, data_out and done; resuming gives bit-identical results.
REQ-022 Decrypting the encoder's output under the same key and ROUNDS/DELTA SHALL reproduce the original plaintext exactly.

Reset
REQ-023 On reset: state=IDLE, data_out=0, done=0, y0=z0=y1=z1=0, sum=0, counter=0, regardless of state, including mid-block.
REQ-024 First enabled edge after reset release SHALL be a load edge.

Configuration
REQ-025 Macro DECODER_KEY_LATCH_EN defined: key_in captured into an internal 128-bit register on the load edge, and all steps of that block use the captured key.
REQ-026 Macro DECODER_KEY_LATCH_EN undefined: steps use live key_in every cycle, and the caller must hold key_in stable for the whole block. Reset value of the latch register is 0.

Verification
REQ-027 Zero vector: key=0, data_in = encoder output for plaintext 0 -> data_out=0, done high on edge 66 after load.
REQ-028 Round trip: plaintext 128'h0123456789ABCDEF_FEDCBA9876543210, key 128'h0F0E0D0C_0B0A0908_07060504_03020100, encode then decode -> data_out equals the plaintext; lane1 uses independent values from lane0.
REQ-029 Stall: same as REQ-028 with enable deasserted for 7 cycles at edge 30 -> identical data_out, done delayed by exactly 7 cycles.
REQ-030 Reset mid-block: assert reset at edge 20 -> data_out=0, done=0 immediately; next block decodes correctly.
REQ-031 Back-to-back: two ciphertexts with enable held high -> done pulses for one cycle each, 66 cycles apart; data_out holds block 1 until block 2 OUTPUT.
REQ-032 Key change mid-block at edge 10: with DECODER_KEY_LATCH_EN -> correct plaintext; without it -> plaintext differs from expected.

Source files
------------

// File: rtl/decoder.sv
// -----------------------------------------------------------------------------
// decoder
//
// Two-lane XTEA-style block decryptor. A 128-bit ciphertext holds two
// independent 64-bit lanes that share one key schedule (sum and key word).
// Each cipher cycle is a z-step followed by a y-step. The key schedule runs
// backwards from ROUNDS*DELTA, so this block inverts the matching encoder.
//
// Parameters:
//   ROUNDS  number of cipher cycles (1..255)
//   DELTA   round constant
//
// Ports:
//   clock     single clock, rising edge
//   reset     asynchronous active-high reset, clears all state
//   enable    advance enable; when low every register holds
//   data_in   ciphertext; lane0 y=[31:0] z=[63:32], lane1 y=[95:64] z=[127:96]
//   key_in    key words k[n] = key_in[32n+31:32n]
//   data_out  plaintext, same packing as data_in, held until the next block
//   done      plaintext valid; high from the output edge until the next load
//
// Configuration macro:
//   DECODER_KEY_LATCH_EN  when defined, key_in is captured on the load edge
//                         and the whole block uses the captured copy; when
//                         undefined, every step uses the live key_in.
// -----------------------------------------------------------------------------
module decoder #(
  parameter int          ROUNDS = 32,
  parameter logic [31:0] DELTA  = 32'h9E3779B9
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         enable,
  input  logic [127:0] data_in,
  input  logic [127:0] key_in,
  output logic [127:0] data_out,
  output logic         done
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ZSTEP  = 2'd1;
  localparam logic [1:0] YSTEP  = 2'd2;
  localparam logic [1:0] OUTPUT = 2'd3;

  // Starting sum is the encoder's final sum, truncated to 32 bits.
  localparam logic [31:0] SUM_INIT = 32'(ROUNDS) * DELTA;
  localparam logic [8:0]  ROUNDS_W = 9'(ROUNDS);

  logic [1:0]   state;
  logic [31:0]  y0, z0, y1, z1;
  logic [31:0]  sum;
  logic [8:0]   round_cnt;
  logic [8:0]   round_next;
  logic [127:0] key_use;
  logic [31:0]  z_key;
  logic [31:0]  y_key;

  function automatic logic [31:0] mix(input logic [31:0] v);
    return ((v << 4) ^ (v >> 5)) + v;
  endfunction

  function automatic logic [31:0] key_word(input logic [127:0] k, input logic [1:0] idx);
    return k[{idx, 5'b0} +: 32];
  endfunction

`ifdef DECODER_KEY_LATCH_EN
  // Key captured on the load edge so the caller may change key_in mid-block.
  logic [127:0] key_reg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      key_reg <= '0;
    end else if (enable && state == IDLE) begin
      key_reg <= key_in;
    end
  end

  assign key_use = key_reg;
`else
  assign key_use = key_in;
`endif

  // z-step selects the key word from sum[12:11] before the decrement; the
  // y-step runs a cycle later, so it naturally sees the decremented sum.
  assign z_key      = sum + key_word(key_use, sum[12:11]);
  assign y_key      = sum + key_word(key_use, sum[1:0]);
  assign round_next = round_cnt + 9'd1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      y0        <= '0;
      z0        <= '0;
      y1        <= '0;
      z1        <= '0;
      sum       <= '0;
      round_cnt <= '0;
      data_out  <= '0;
      done      <= 1'b0;
    end else if (enable) begin
      case (state)
        IDLE: begin
          y0        <= data_in[31:0];
          z0        <= data_in[63:32];
          y1        <= data_in[95:64];
          z1        <= data_in[127:96];
          sum       <= SUM_INIT;
          round_cnt <= '0;
          done      <= 1'b0;
          state     <= ZSTEP;
        end
        ZSTEP: begin
          z0    <= z0 - (mix(y0) ^ z_key);
          z1    <= z1 - (mix(y1) ^ z_key);
          sum   <= sum - DELTA;
          state <= YSTEP;
        end
        YSTEP: begin
          y0        <= y0 - (mix(z0) ^ y_key);
          y1        <= y1 - (mix(z1) ^ y_key);
          round_cnt <= round_next;
          state     <= (round_next < ROUNDS_W) ? ZSTEP : OUTPUT;
        end
        OUTPUT: begin
          data_out <= {z1, y1, z0, y0};
          done     <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_decoder.sv
// -----------------------------------------------------------------------------
// tb_decoder
//
// Self-checking bench for decoder. Ciphertexts are produced by a local
// encryption model; expected plaintexts and latencies are hand-written
// constants. A vector table drives back-to-back blocks, followed by
// hand-written sequences for hold, stall, mid-block reset and key change.
// -----------------------------------------------------------------------------
module tb_decoder;

  localparam int          ROUNDS    = 32;
  localparam logic [31:0] DELTA     = 32'h9E3779B9;
  localparam int          LATENCY   = 66;
  localparam int          MAX_EDGES = 400;
  localparam int          NUM_VECS  = 5;

  logic         clock = 1'b0;
  logic         reset;
  logic         enable;
  logic [127:0] data_in;
  logic [127:0] key_in;
  logic [127:0] data_out;
  logic         done;

  int           vectors     = 0;
  int           miscompares = 0;
  logic [127:0] prev_expected;

  typedef struct {
    logic [127:0] plain;
    logic [127:0] key;
  } vec_t;

  vec_t vecs[NUM_VECS];

  decoder #(
    .ROUNDS(ROUNDS),
    .DELTA (DELTA)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .enable  (enable),
    .data_in (data_in),
    .key_in  (key_in),
    .data_out(data_out),
    .done    (done)
  );

  always #5 clock = ~clock;

  // Encryption of one 64-bit lane, y=[31:0] z=[63:32].
  function automatic logic [63:0] enc_lane(input logic [63:0] v, input logic [127:0] k);
    logic [31:0] y;
    logic [31:0] z;
    logic [31:0] s;
    int          idx;
    y = v[31:0];
    z = v[63:32];
    s = 32'd0;
    for (int i = 0; i < ROUNDS; i++) begin
      idx = int'(s & 32'd3);
      y   = y + ((((z << 4) ^ (z >> 5)) + z) ^ (s + k[idx*32 +: 32]));
      s   = s + DELTA;
      idx = int'((s >> 11) & 32'd3);
      z   = z + ((((y << 4) ^ (y >> 5)) + y) ^ (s + k[idx*32 +: 32]));
    end
    return {z, y};
  endfunction

  function automatic logic [127:0] encrypt(input logic [127:0] p, input logic [127:0] k);
    return {enc_lane(p[127:64], k), enc_lane(p[63:0], k)};
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] actual,
                             input logic [127:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic checkDiffers(input string name, input logic [127:0] actual,
                              input logic [127:0] forbidden);
    vectors++;
    if (actual === forbidden) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, required a value other than %h", name, actual, forbidden);
    end
  endtask

  // Runs one block from the load edge. Edges are counted from the load edge
  // (edge 1). Optional stall, key change and reset are applied after the
  // given edge; a value of 0 disables each one.
  task automatic applyStimulus(input logic [127:0] plain, input logic [127:0] key,
                               input int stall_at, input int stall_len,
                               input int key_change_at, input logic [127:0] key2,
                               input int reset_at,
                               output int edges, output logic [127:0] result);
    logic got;
    got    = 1'b0;
    edges  = -1;
    result = '0;
    data_in = encrypt(plain, key);
    key_in  = key;
    enable  = 1'b1;
    for (int e = 1; e <= MAX_EDGES && !got; e++) begin
      @(posedge clock);
      #1;
      if (e == 1) begin
        data_in = ~data_in ^ 128'h5A5A_A5A5_3C3C_C3C3_0F0F_F0F0_9696_6969;
        checkOutput("done_clears_on_load", {127'b0, done}, 128'd0);
      end
      if (e == 33) begin
        checkOutput("out_holds_mid_block", data_out, prev_expected);
      end
      if (e == stall_at) enable = 1'b0;
      if (stall_at > 0 && e == stall_at + stall_len) enable = 1'b1;
      if (e == key_change_at) key_in = key2;
      if (e == reset_at) begin
        reset = 1'b1;
        #1;
        checkOutput("reset_clears_out", data_out, 128'd0);
        checkOutput("reset_clears_done", {127'b0, done}, 128'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        prev_expected = '0;
        return;
      end
      if (done) begin
        got    = 1'b1;
        edges  = e;
        result = data_out;
      end
    end
  endtask

  initial begin
    int           edges;
    logic [127:0] result;

    vecs[0] = '{plain: 128'd0, key: 128'd0};
    vecs[1] = '{plain: 128'h0123456789ABCDEF_FEDCBA9876543210,
                key:   128'h0F0E0D0C_0B0A0908_07060504_03020100};
    vecs[2] = '{plain: {128{1'b1}}, key: {128{1'b1}}};
    vecs[3] = '{plain: 128'h80000000_00000001_00000000_FFFFFFFF,
                key:   128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0};
    vecs[4] = '{plain: 128'h11111111_22222222_33333333_44444444,
                key:   128'h00000001_00000000_00000000_80000000};

    reset         = 1'b1;
    enable        = 1'b0;
    data_in       = '0;
    key_in        = '0;
    prev_expected = '0;
    repeat (3) @(posedge clock);
    #1;
    checkOutput("reset_data_out", data_out, 128'd0);
    checkOutput("reset_done", {127'b0, done}, 128'd0);
    reset = 1'b0;

    // Back-to-back blocks with enable held high.
    for (int i = 0; i < NUM_VECS; i++) begin
      applyStimulus(vecs[i].plain, vecs[i].key, 0, 0, 0, '0, 0, edges, result);
      checkOutput($sformatf("vec%0d_plaintext", i), result, vecs[i].plain);
      checkOutput($sformatf("vec%0d_latency", i), 128'(edges), 128'(LATENCY));
      prev_expected = vecs[i].plain;
    end

    // done and data_out hold while enable is low after a block.
    enable = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    checkOutput("done_holds_idle", {127'b0, done}, 128'd1);
    checkOutput("out_holds_idle", data_out, prev_expected);

    // Stall for 7 edges after edge 30.
    applyStimulus(vecs[1].plain, vecs[1].key, 30, 7, 0, '0, 0, edges, result);
    checkOutput("stall_plaintext", result, vecs[1].plain);
    checkOutput("stall_latency", 128'(edges), 128'(LATENCY + 7));
    prev_expected = vecs[1].plain;

    // Reset mid-block, then a clean block.
    applyStimulus(vecs[3].plain, vecs[3].key, 0, 0, 0, '0, 20, edges, result);
    applyStimulus(vecs[1].plain, vecs[1].key, 0, 0, 0, '0, 0, edges, result);
    checkOutput("post_reset_plaintext", result, vecs[1].plain);
    checkOutput("post_reset_latency", 128'(edges), 128'(LATENCY));
    prev_expected = vecs[1].plain;

    // Key changed after edge 10.
    applyStimulus(vecs[1].plain, vecs[1].key, 0, 0, 10, ~vecs[1].key, 0, edges, result);
`ifdef DECODER_KEY_LATCH_EN
    checkOutput("key_change_latched", result, vecs[1].plain);
`else
    checkDiffers("key_change_live", result, vecs[1].plain);
`endif
    checkOutput("key_change_latency", 128'(edges), 128'(LATENCY));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
